// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the packed-BCD arithmetic unit:
//                operation encodings, FSM state type and single-digit
//                add/subtract adjust helpers plus a nibble validity check.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Operation encodings on op_i; 2'b11 is reserved and behaves as ADD
    localparam logic [1:0] BCD_ADD = 2'b00;
    localparam logic [1:0] BCD_SUB = 2'b01;
    localparam logic [1:0] BCD_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    // One BCD digit add with carry: returns {carry_out, digit}
    function automatic logic [4:0] bcdAddDigit(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9) begin
            bcdAddDigit = {1'b1, 4'(s - 5'd10)};
        end else begin
            bcdAddDigit = {1'b0, s[3:0]};
        end
    endfunction

    // One BCD digit subtract with borrow: returns {borrow_out, digit}.
    // The 5-bit difference is negative exactly when its top bit is set.
    function automatic logic [4:0] bcdSubDigit(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       bin);
        logic [4:0] d;
        d = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        if (d[4]) begin
            bcdSubDigit = {1'b1, 4'(d + 5'd10)};
        end else begin
            bcdSubDigit = {1'b0, d[3:0]};
        end
    endfunction

    function automatic logic nibbleValid(input logic [3:0] n);
        nibbleValid = (n <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_row_mul.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_row_mul
//  Description : Combinational DIGITS-digit x 1-digit packed-BCD multiplier.
//                Each digit product a[i]*d (0..81) is split into a units
//                digit (weight i) and a tens digit (weight i+1); the two rows
//                are then summed with a ripple BCD adder.
//  Ports       : i_a     - multiplicand, DIGITS packed BCD digits
//                i_digit - single BCD multiplier digit
//                o_prod  - product, DIGITS+1 packed BCD digits
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_row_mul
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [4*DIGITS-1:0]     i_a,
    input  logic [3:0]              i_digit,
    output logic [4*(DIGITS+1)-1:0] o_prod
);

    logic [4*DIGITS-1:0] w_lo;
    logic [4*DIGITS-1:0] w_hi;
    logic [DIGITS:0]     w_carry;

    genvar gi;

    // Per-digit product table: units and tens of a[i]*d
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_prod
            logic [7:0] w_p;
            assign w_p              = {4'h0, i_a[4*gi +: 4]} * {4'h0, i_digit};
            assign w_lo[4*gi +: 4]  = 4'(w_p % 8'd10);
            assign w_hi[4*gi +: 4]  = 4'(w_p / 8'd10);
        end
    endgenerate

    // Digit 0 receives only a units digit, so no add and no carry
    assign o_prod[3:0] = w_lo[3:0];
    assign w_carry[0]  = 1'b0;
    assign w_carry[1]  = 1'b0;

    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_ripple
            assign {w_carry[gi+1], o_prod[4*gi +: 4]} =
                bcdAddDigit(w_lo[4*gi +: 4], w_hi[4*(gi-1) +: 4], w_carry[gi]);
        end
    endgenerate

    // Top digit: tens of the highest product plus incoming carry; the full
    // product is at most 9*(10^DIGITS-1), so this never exceeds 9
    assign o_prod[4*DIGITS +: 4] = w_hi[4*(DIGITS-1) +: 4] + {3'b000, w_carry[DIGITS]};

endmodule
`default_nettype wire

// File: rtl/bcd_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_alu_seq
//  Description : Multi-digit packed-BCD ALU with valid/ready handshakes.
//                ADD/SUB complete in one cycle; MUL is digit-serial, one
//                multiplier digit per cycle, DIGITS cycles in MULT.
//  Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//                in_valid_i / in_ready_o - request handshake (ready in IDLE)
//                op_i, ci_i, a_i, b_i    - operation, carry/borrow in, operands
//                out_valid_o/out_ready_i - result handshake (held in DONE)
//                o_o, c_o, err_o         - result, carry/borrow out, bad digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_alu_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [1:0]            op_i,
    input  logic                  ci_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [8*DIGITS-1:0]   o_o,
    output logic                  c_o,
    output logic                  err_o
);

    localparam int                c_OPW  = 4 * DIGITS;
    localparam int                c_ADDW = 4 * (DIGITS + 1);
    localparam int                c_CNTW = $clog2(DIGITS);
    localparam logic [c_CNTW-1:0] c_LAST = c_CNTW'(DIGITS - 1);

    state_t              r_state;
    logic [c_OPW-1:0]    r_a;
    // Upper DIGITS digits: running partial sum. Lower DIGITS digits start as
    // the multiplier; each step consumes its lowest digit and the finished
    // product digit shifts in from above, so after DIGITS steps the whole
    // register holds A*B.
    logic [2*c_OPW-1:0]  r_acc;
    logic [c_CNTW-1:0]   r_cnt;
    logic [2*c_OPW-1:0]  r_out;
    logic                r_carry;
    logic                r_err;

    logic [2*DIGITS-1:0] w_bad;
    logic                w_err;
    logic [c_ADDW-1:0]   w_row;
    logic [c_ADDW-1:0]   w_x;
    logic [c_ADDW-1:0]   w_y;
    logic [c_ADDW-1:0]   w_sum;
    logic                w_cin;
    logic                w_sub;
    logic [DIGITS:0]     w_chain;
    logic [2*c_OPW-1:0]  w_accNext;

    genvar gi;

    // Operand digit validity, evaluated on the values being accepted
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign w_bad[gi]          = !nibbleValid(a_i[4*gi +: 4]);
            assign w_bad[DIGITS + gi] = !nibbleValid(b_i[4*gi +: 4]);
        end
    endgenerate
    assign w_err = |w_bad;

    bcd_row_mul #(
        .DIGITS (DIGITS)
    ) u_rowMul (
        .i_a     (r_a),
        .i_digit (r_acc[3:0]),
        .o_prod  (w_row)
    );

    // Shared adder: operands from the inputs in IDLE (ADD/SUB), from the
    // accumulator and current row product in MULT
    always_comb begin
        w_x   = {4'h0, a_i};
        w_y   = {4'h0, b_i};
        w_cin = ci_i;
        w_sub = (op_i == BCD_SUB);
        if (r_state == MULT) begin
            w_x   = {4'h0, r_acc[2*c_OPW-1 -: c_OPW]};
            w_y   = w_row;
            w_cin = 1'b0;
            w_sub = 1'b0;
        end
    end

    assign w_chain[0] = w_cin;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adder
            assign {w_chain[gi+1], w_sum[4*gi +: 4]} = w_sub ?
                bcdSubDigit(w_x[4*gi +: 4], w_y[4*gi +: 4], w_chain[gi]) :
                bcdAddDigit(w_x[4*gi +: 4], w_y[4*gi +: 4], w_chain[gi]);
        end
    endgenerate

    // Top digit is only consumed in MULT, where the running sum is bounded
    // below 10^(DIGITS+1) and no decimal adjust is needed
    assign w_sum[4*DIGITS +: 4] = w_x[4*DIGITS +: 4] + w_y[4*DIGITS +: 4]
                                + {3'b000, w_chain[DIGITS]};

    assign w_accNext = {w_sum, r_acc[c_OPW-1:4]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_err <= w_err;
                        if (op_i == BCD_MUL) begin
                            r_a     <= a_i;
                            r_acc   <= {{c_OPW{1'b0}}, b_i};
                            r_cnt   <= '0;
                            r_carry <= 1'b0;
                            r_state <= MULT;
                        end else begin
                            r_out   <= w_err ? '0 : {{c_OPW{1'b0}}, w_sum[c_OPW-1:0]};
                            r_carry <= w_err ? 1'b0 : w_chain[DIGITS];
                            r_state <= DONE;
                        end
                    end
                end
                MULT: begin
                    r_acc <= w_accNext;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_out   <= r_err ? '0 : w_accNext;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == IDLE);
    assign out_valid_o = (r_state == DONE);
    assign o_o         = r_out;
    assign c_o         = r_carry;
    assign err_o       = r_err;

endmodule
`default_nettype wire
